sdram_arbiter: RTL and testbench

Two-client request arbiter sitting directly upstream of the SDRAM controller. Each client presents a 24-bit 16-bit-word address, a read/write flag, 32-bit write data and a data width. The arbiter grants one client at a time and drives the controller's `enable`/`ready` handshake so that no request is lost, including requests that collide with an internal auto-refresh. It returns read data and a one-cycle acknowledge to the granted client, and flags a sticky error if the controller stops responding.

---
 rtl/sdram_pkg.sv | 19 +
 rtl/rr_pick2.sv | 20 ++
 rtl/sdram_arbiter.sv | 143 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM request path.
// Imported by the arbiter and its picker.
package sdram_pkg;

  localparam int SD_ADDR_W  = 24;
  localparam int SD_DATA_W  = 32;
  localparam int SD_WIDTH_W = 2;

  localparam logic [SD_WIDTH_W-1:0] W8  = 2'd0;
  localparam logic [SD_WIDTH_W-1:0] W16 = 2'd1;
  localparam logic [SD_WIDTH_W-1:0] W32 = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way request picker: fixed priority to port 0,
// or round-robin against the last grant.
module rr_pick2 (
  input  logic [1:0] reqs,
  input  logic       last,
  input  logic       prio0,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |reqs;
    grant = 1'b0;
    if (reqs == 2'b11)
      grant = prio0 ? 1'b0 : ~last;
    else
      grant = reqs[1];
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-client arbiter in front of the SDRAM controller,
// with enable/ready handshake, timeout and sticky error.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter bit PRIO0   = 1'b0,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic [SD_ADDR_W-1:0]  p0_addr,
  input  logic                  p0_write,
  input  logic [SD_DATA_W-1:0]  p0_wdata,
  input  logic [SD_WIDTH_W-1:0] p0_width,
  output logic                  p0_ack,
  output logic [SD_DATA_W-1:0]  p0_rdata,
  input  logic                  p1_req,
  input  logic [SD_ADDR_W-1:0]  p1_addr,
  input  logic                  p1_write,
  input  logic [SD_DATA_W-1:0]  p1_wdata,
  input  logic [SD_WIDTH_W-1:0] p1_width,
  output logic                  p1_ack,
  output logic [SD_DATA_W-1:0]  p1_rdata,
  output logic                  sd_enable,
  output logic [SD_ADDR_W-1:0]  sd_addr,
  output logic                  sd_write,
  output logic [SD_DATA_W-1:0]  sd_wdata,
  output logic [SD_WIDTH_W-1:0] sd_width,
  input  logic                  sd_ready,
  input  logic [SD_DATA_W-1:0]  sd_rdata,
  output logic                  err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic       gnt, last, seen_ready;
  logic [7:0] cnt;
  logic       pick_gnt, pick_vld;
  logic       tmo, go, drop, done, abort;

  rr_pick2 u_pick (
    .reqs  ({p1_req, p0_req}),
    .last  (last),
    .prio0 (PRIO0),
    .grant (pick_gnt),
    .valid (pick_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (go) state_nx = ISSUE;
      ISSUE: begin
        if (abort)     state_nx = IDLE;
        else if (drop) state_nx = WAIT;
      end
      WAIT:    if (done || abort) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Ready low before it was ever seen high means the
  // controller is still initialising, not accepting.
  always_comb begin
    tmo   = seen_ready && (cnt >= TO_LAST);
    go    = 1'b0;
    drop  = 1'b0;
    done  = 1'b0;
    abort = 1'b0;
    unique case (state)
      IDLE:  go = pick_vld;
      ISSUE: begin
        abort = tmo;
        drop  = !tmo && seen_ready && !sd_ready;
      end
      WAIT: begin
        done  = sd_ready;
        abort = tmo && !sd_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt        <= 1'b0;
      last       <= 1'b1;
      seen_ready <= 1'b0;
      cnt        <= '0;
      sd_enable  <= 1'b0;
      sd_addr    <= '0;
      sd_write   <= 1'b0;
      sd_wdata   <= '0;
      sd_width   <= '0;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
      err        <= 1'b0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      if (sd_ready)
        seen_ready <= 1'b1;
      if (state != IDLE && seen_ready)
        cnt <= cnt + 8'd1;
      if (go) begin
        gnt       <= pick_gnt;
        last      <= pick_gnt;
        cnt       <= '0;
        sd_enable <= 1'b1;
        sd_addr   <= pick_gnt ? p1_addr  : p0_addr;
        sd_write  <= pick_gnt ? p1_write : p0_write;
        sd_wdata  <= pick_gnt ? p1_wdata : p0_wdata;
        sd_width  <= pick_gnt ? p1_width : p0_width;
      end
      if (drop)
        sd_enable <= 1'b0;
      if (done || abort) begin
        sd_enable <= 1'b0;
        if (gnt) p1_ack <= 1'b1;
        else     p0_ack <= 1'b1;
        if (abort) begin
          if (gnt) p1_rdata <= '0;
          else     p0_rdata <= '0;
        end else if (!sd_write) begin
          if (gnt) p1_rdata <= sd_rdata;
          else     p0_rdata <= sd_rdata;
        end
      end
      if (abort)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small
// behavioural SDRAM controller model.
module tb_sdram_arbiter;

  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p1_req;
  logic [23:0] p0_addr, p1_addr;
  logic        p0_write, p1_write;
  logic [31:0] p0_wdata, p1_wdata;
  logic [1:0]  p0_width, p1_width;
  logic        p0_ack, p1_ack;
  logic [31:0] p0_rdata, p1_rdata;
  logic        sd_enable, sd_write, sd_ready, err;
  logic [23:0] sd_addr;
  logic [31:0] sd_wdata, sd_rdata;
  logic [1:0]  sd_width;

  logic        q_p0_ack, q_p1_ack;
  logic [31:0] q_p0_rdata, q_p1_rdata;
  logic        q_sd_enable, q_sd_write, q_err;
  logic [23:0] q_sd_addr;
  logic [31:0] q_sd_wdata;
  logic [1:0]  q_sd_width;

  int n_checks = 0;
  int n_fail   = 0;

  // controller model configuration (driven by the tests)
  logic        m_init = 1'b0;
  logic        m_hold = 1'b0;
  int          m_lat  = 6;
  int          m_ignore = 0;
  logic [31:0] m_data = '0;
  // controller model state
  logic        m_busy;
  int          m_cnt, m_skip, m_issues = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(.PRIO0(1'b0), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_write(p0_write),
    .p0_wdata(p0_wdata), .p0_width(p0_width),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_write(p1_write),
    .p1_wdata(p1_wdata), .p1_width(p1_width),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .sd_enable(sd_enable), .sd_addr(sd_addr), .sd_write(sd_write),
    .sd_wdata(sd_wdata), .sd_width(sd_width),
    .sd_ready(sd_ready), .sd_rdata(sd_rdata), .err(err)
  );

  sdram_arbiter #(.PRIO0(1'b1), .TIMEOUT(TO)) dut_prio (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_write(p0_write),
    .p0_wdata(p0_wdata), .p0_width(p0_width),
    .p0_ack(q_p0_ack), .p0_rdata(q_p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_write(p1_write),
    .p1_wdata(p1_wdata), .p1_width(p1_width),
    .p1_ack(q_p1_ack), .p1_rdata(q_p1_rdata),
    .sd_enable(q_sd_enable), .sd_addr(q_sd_addr), .sd_write(q_sd_write),
    .sd_wdata(q_sd_wdata), .sd_width(q_sd_width),
    .sd_ready(sd_ready), .sd_rdata(sd_rdata), .err(q_err)
  );

  // Ready low until init, then: ignore enable m_ignore
  // edges (refresh), capture, stay busy m_lat cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_cnt    <= 0;
      m_skip   <= 0;
      sd_ready <= m_init;
      sd_rdata <= '0;
    end else if (!m_init) begin
      sd_ready <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        sd_ready <= 1'b1;
        sd_rdata <= m_data;
        m_busy   <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (!sd_ready) begin
      sd_ready <= 1'b1;
    end else if (sd_enable && !m_hold) begin
      if (m_skip < m_ignore) begin
        m_skip <= m_skip + 1;
      end else begin
        m_skip   <= 0;
        sd_ready <= 1'b0;
        m_busy   <= 1'b1;
        m_cnt    <= m_lat - 1;
        m_issues <= m_issues + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({sd_enable, p0_ack, p1_ack, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctl: en/ack0/ack1/err=%b required 0000",
               {sd_enable, p0_ack, p1_ack, err});
    end
    n_checks++;
    if (sd_addr !== 24'h0 || p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h rd0=%h rd1=%h required 0",
               sd_addr, p0_rdata, p1_rdata);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_init_hold();
    int acks = 0;
    logic got = 1'b0;
    p0_addr = 24'h000123;
    p0_write = 1'b0;
    p0_req = 1'b1;
    for (int k = 0; k < TO + 20; k++) begin
      step();
      if (p0_ack) acks++;
    end
    n_checks++;
    if (sd_enable !== 1'b1 || err !== 1'b0 || acks != 0) begin
      n_fail++;
      $display("FAIL init_hold: en=%b err=%b acks=%0d required 1 0 0",
               sd_enable, err, acks);
    end
    m_data = 32'h12345678;
    m_lat = 6;
    m_init = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (p0_ack) begin
        got = 1'b1;
        break;
      end
    end
    p0_req = 1'b0;
    n_checks++;
    if (!got || p0_rdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL init_done: ack=%b rdata=%h required 1 12345678",
               got, p0_rdata);
    end
    step();
  endtask

  task automatic test_single_read();
    int en_cyc = 0;
    int acks = 0;
    logic got = 1'b0;
    m_data = 32'hDEADBEEF;
    p0_addr = 24'h000123;
    p0_write = 1'b0;
    p0_req = 1'b1;
    step();
    n_checks++;
    if (sd_enable !== 1'b1 || sd_addr !== 24'h000123 || sd_write !== 1'b0) begin
      n_fail++;
      $display("FAIL grant_latency: en=%b addr=%h wr=%b required 1 000123 0",
               sd_enable, sd_addr, sd_write);
    end
    en_cyc = 1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (sd_enable) en_cyc++;
      if (p0_ack) begin
        acks++;
        got = 1'b1;
        p0_req = 1'b0;
        break;
      end
    end
    repeat (3) begin
      step();
      if (p0_ack) acks++;
      if (sd_enable) en_cyc++;
    end
    n_checks++;
    if (en_cyc != 2) begin
      n_fail++;
      $display("FAIL enable_width: cycles=%0d required 2", en_cyc);
    end
    n_checks++;
    if (!got || acks != 1 || p0_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_read: acks=%0d rdata=%h required 1 deadbeef",
               acks, p0_rdata);
    end
  endtask

  task automatic test_refresh();
    int issues0 = m_issues;
    logic got = 1'b0;
    m_ignore = 7;
    m_data = 32'h13572468;
    p1_addr = 24'h012345;
    p1_write = 1'b0;
    p1_req = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (p1_ack) begin
        got = 1'b1;
        p1_req = 1'b0;
        break;
      end
    end
    p1_req = 1'b0;
    m_ignore = 0;
    repeat (3) step();
    n_checks++;
    if (!got || p1_rdata !== 32'h13572468) begin
      n_fail++;
      $display("FAIL refresh_ack: ack=%b rdata=%h required 1 13572468",
               got, p1_rdata);
    end
    n_checks++;
    if (m_issues - issues0 != 1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL refresh_once: issues=%0d err=%b required 1 0",
               m_issues - issues0, err);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] seq = '0;
    int n = 0;
    int q0 = 0;
    int q1 = 0;
    logic [3:0] exp_seq = 4'b1010;
    m_data = 32'h5A5A0001;
    m_lat = 3;
    p0_write = 1'b0;
    p1_write = 1'b0;
    p0_req = 1'b1;
    p1_req = 1'b1;
    for (int k = 0; k < 80 && n < 4; k++) begin
      step();
      if (q_p0_ack) q0++;
      if (q_p1_ack) q1++;
      if (p0_ack || p1_ack) begin
        seq[n] = p1_ack;
        n++;
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (3) step();
    n_checks++;
    if (n != 4 || seq !== exp_seq) begin
      n_fail++;
      $display("FAIL rr_order: n=%0d seq(lsb first)=%b required 4 1010",
               n, seq);
    end
    n_checks++;
    if (q0 != 4 || q1 != 0) begin
      n_fail++;
      $display("FAIL prio0_fixed: p0 grants=%0d p1 grants=%0d required 4 0",
               q0, q1);
    end
    n_checks++;
    if (p1_rdata !== 32'h5A5A0001) begin
      n_fail++;
      $display("FAIL rr_rdata: rdata=%h required 5a5a0001", p1_rdata);
    end
  endtask

  task automatic test_write();
    logic seen = 1'b0;
    logic got = 1'b0;
    m_data = 32'hBAD0BAD0;
    p1_addr = 24'hC00200;
    p1_write = 1'b1;
    p1_wdata = 32'hCAFEF00D;
    p1_width = 2'd1;
    p1_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (sd_enable) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen || sd_addr !== 24'hC00200 || sd_write !== 1'b1 ||
        sd_wdata !== 32'hCAFEF00D || sd_width !== 2'd1) begin
      n_fail++;
      $display("FAIL write_pass: en=%b addr=%h wr=%b wd=%h w=%0d required 1 c00200 1 cafef00d 1",
               seen, sd_addr, sd_write, sd_wdata, sd_width);
    end
    for (int k = 0; k < 40; k++) begin
      step();
      if (p1_ack) begin
        got = 1'b1;
        p1_req = 1'b0;
        break;
      end
    end
    p1_req = 1'b0;
    p1_write = 1'b0;
    step();
    n_checks++;
    if (!got || p1_rdata !== 32'h5A5A0001) begin
      n_fail++;
      $display("FAIL write_rdata: ack=%b rdata=%h required 1 5a5a0001",
               got, p1_rdata);
    end
  endtask

  task automatic test_timeout();
    logic early = 1'b0;
    m_hold = 1'b1;
    p0_addr = 24'h000777;
    p0_write = 1'b0;
    p0_req = 1'b1;
    step();
    for (int k = 1; k < TO; k++) begin
      step();
      if (err || p0_ack) early = 1'b1;
    end
    step();
    n_checks++;
    if (early) begin
      n_fail++;
      $display("FAIL timeout_early: err or ack before cycle %0d", TO);
    end
    n_checks++;
    if (err !== 1'b1 || p0_ack !== 1'b1 || p0_rdata !== 32'h0 ||
        sd_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: err=%b ack=%b rdata=%h en=%b required 1 1 0 0",
               err, p0_ack, p0_rdata, sd_enable);
    end
    p0_req = 1'b0;
    m_hold = 1'b0;
    repeat (4) step();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b required 1", err);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic in_wait = 1'b0;
    logic got = 1'b0;
    int acks = 0;
    m_lat = 10;
    m_data = 32'h11112222;
    p0_addr = 24'h000050;
    p0_req = 1'b1;
    step();
    for (int k = 0; k < 20; k++) begin
      step();
      if (!sd_enable) begin
        in_wait = 1'b1;
        break;
      end
    end
    step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (!in_wait || sd_enable !== 1'b0 || err !== 1'b0 ||
        sd_addr !== 24'h0 || p1_rdata !== 32'h0 || p0_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: wait=%b en=%b err=%b addr=%h rd1=%h ack=%b required 1 0 0 0 0 0",
               in_wait, sd_enable, err, sd_addr, p1_rdata, p0_ack);
    end
    p0_req = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (p0_ack || p1_ack) acks++;
    end
    n_checks++;
    if (acks != 0) begin
      n_fail++;
      $display("FAIL reset_no_ack: acks=%0d required 0", acks);
    end
    m_lat = 4;
    m_data = 32'h0BADCAFE;
    p1_addr = 24'h400010;
    p1_write = 1'b0;
    p1_req = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (p1_ack) begin
        got = 1'b1;
        p1_req = 1'b0;
        break;
      end
    end
    p1_req = 1'b0;
    n_checks++;
    if (!got || p1_rdata !== 32'h0BADCAFE || err !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_read: ack=%b rdata=%h err=%b required 1 0badcafe 0",
               got, p1_rdata, err);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    p0_req = 1'b0;
    p1_req = 1'b0;
    p0_addr = '0;
    p1_addr = '0;
    p0_write = 1'b0;
    p1_write = 1'b0;
    p0_wdata = 32'h0;
    p1_wdata = 32'h0;
    p0_width = 2'd2;
    p1_width = 2'd2;
    test_reset();
    test_init_hold();
    test_single_read();
    test_refresh();
    test_round_robin();
    test_write();
    test_timeout();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
